sumnb_seq: RTL and testbench

Parametrised, multi-cycle add/subtract unit, the next generation of the team's 4-bit ripple adder. It processes a WIDTH-bit operand pair CHUNK bits per clock and ripples the carry through a registered carry flop between chunks. It uses a valid/ready handshake on input and output, so it can sit between the operand-entry logic and the BCD/7-segment display path without a combinational carry chain spanning the full width.

---
 rtl/sumnb_pkg.sv | 23 ++
 rtl/sumnb_seq_sum_chunk.sv | 29 ++
 rtl/sumnb_seq.sv | 139 +++++++++++++
 tb/tb_sumnb_seq.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sumnb_pkg.sv
// Shared types and defaults for the chunked multi-cycle add/subtract unit.
// Holds the FSM encoding and the 1-bit full-adder cell the chunk adder is built from.
package sumnb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
        logic s;
        logic co;
        s  = a ^ b ^ ci;
        co = (a & b) | (ci & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/sumnb_seq_sum_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the parent can form signed overflow on the final chunk.
module sum_chunk
    import sumnb_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic c;

    always_comb begin
        s     = '0;
        c     = ci;
        c_msb = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb     = c;
            {c, s[i]} = full_add(a[i], b[i], c);
        end
        co = c;
    end

endmodule

// File: rtl/sumnb_seq.sv
// Multi-cycle add/subtract: CHUNK bits per clock, carry held in a flop between chunks.
// Result valid NCHUNK cycles after accept; held stable in DONE until out_ready.
module sumnb_seq
    import sumnb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    input  logic             sub,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] So,
    output logic             Co,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("sumnb_seq: WIDTH must be a positive multiple of CHUNK");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] so_q, so_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             chunk_c_msb;

    assign chunk_a = a_q[idx_q*CHUNK +: CHUNK];
    assign chunk_b = b_q[idx_q*CHUNK +: CHUNK];

    sum_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (chunk_a),
        .b     (chunk_b),
        .ci    (carry_q),
        .s     (chunk_s),
        .co    (chunk_co),
        .c_msb (chunk_c_msb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        so_d    = so_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction folds into an add: A + ~B + ~Ci.
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    carry_d = Ci ^ sub;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                so_d[idx_q*CHUNK +: CHUNK] = chunk_s;
                carry_d = chunk_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    co_d    = chunk_co;
                    ovf_d   = chunk_c_msb ^ chunk_co;
                    zero_d  = (so_d == '0);
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            so_q    <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            so_q    <= so_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign So        = so_q;
    assign Co        = co_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sumnb_seq.sv
// Bench for sumnb_seq: three instances (CHUNK = 4, 16, 1) at WIDTH = 16,
// directed corner cases plus randomized operations against an arithmetic model.
module tb_sumnb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_s [3];
    logic [15:0] b_s [3];
    logic [15:0] so_s [3];
    logic        ci_s [3];
    logic        sub_s [3];
    logic        iv_s [3];
    logic        ir_s [3];
    logic        ov_s [3];
    logic        or_s [3];
    logic        co_s [3];
    logic        ovf_s [3];
    logic        zero_s [3];

    int tests_run;
    int tests_failed;
    int cur_dut;

    always #5 clk = ~clk;

    sumnb_seq #(.WIDTH(16), .CHUNK(4)) u_dut_c4 (
        .clk(clk), .rst(rst), .A(a_s[0]), .B(b_s[0]), .Ci(ci_s[0]), .sub(sub_s[0]),
        .in_valid(iv_s[0]), .in_ready(ir_s[0]), .So(so_s[0]), .Co(co_s[0]),
        .ovf(ovf_s[0]), .zero(zero_s[0]), .out_valid(ov_s[0]), .out_ready(or_s[0])
    );

    sumnb_seq #(.WIDTH(16), .CHUNK(16)) u_dut_c16 (
        .clk(clk), .rst(rst), .A(a_s[1]), .B(b_s[1]), .Ci(ci_s[1]), .sub(sub_s[1]),
        .in_valid(iv_s[1]), .in_ready(ir_s[1]), .So(so_s[1]), .Co(co_s[1]),
        .ovf(ovf_s[1]), .zero(zero_s[1]), .out_valid(ov_s[1]), .out_ready(or_s[1])
    );

    sumnb_seq #(.WIDTH(16), .CHUNK(1)) u_dut_c1 (
        .clk(clk), .rst(rst), .A(a_s[2]), .B(b_s[2]), .Ci(ci_s[2]), .sub(sub_s[2]),
        .in_valid(iv_s[2]), .in_ready(ir_s[2]), .So(so_s[2]), .Co(co_s[2]),
        .ovf(ovf_s[2]), .zero(zero_s[2]), .out_valid(ov_s[2]), .out_ready(or_s[2])
    );

    function automatic int nch(input int d);
        if (d == 0) return 4;
        if (d == 1) return 1;
        return 16;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s (dut%0d): got %0h expected %0h", tag, cur_dut, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic ci, input logic sb,
                                  output logic [15:0] s, output logic co,
                                  output logic ov, output logic z);
        int ua, ub, uc, ures, sa, sbv, sres;
        ua  = int'(a);
        ub  = int'(b);
        uc  = ci ? 1 : 0;
        sa  = {{16{a[15]}}, a};
        sbv = {{16{b[15]}}, b};
        if (!sb) begin
            ures = ua + ub + uc;
            co   = (ures > 65535);
            sres = sa + sbv + uc;
        end else begin
            ures = ua - ub - uc;
            co   = (ua >= ub + uc);
            sres = sa - sbv - uc;
        end
        s  = ures[15:0];
        ov = (sres > 32767) || (sres < -32768);
        z  = (s == 16'h0000);
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic run_op(input int d, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb, input int hold);
        logic [15:0] e_s;
        logic        e_co, e_ov, e_z;
        int          lat;
        cur_dut = d;
        model(a, b, ci, sb, e_s, e_co, e_ov, e_z);
        a_s[d]   = a;
        b_s[d]   = b;
        ci_s[d]  = ci;
        sub_s[d] = sb;
        iv_s[d]  = 1'b1;
        @(posedge clk); #1;
        iv_s[d] = 1'b0;
        a_s[d]  = 16'($urandom);
        b_s[d]  = 16'($urandom);
        sub_s[d] = 1'($urandom);
        check("in_ready_busy", 32'(ir_s[d]), 32'd0);
        check("out_valid_early", 32'(ov_s[d]), 32'd0);
        lat = 0;
        while (!ov_s[d] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            iv_s[d] = 1'($urandom);
            a_s[d]  = 16'($urandom);
        end
        check("latency", 32'(lat), 32'(nch(d)));
        check("So", 32'(so_s[d]), 32'(e_s));
        check("Co", 32'(co_s[d]), 32'(e_co));
        check("ovf", 32'(ovf_s[d]), 32'(e_ov));
        check("zero", 32'(zero_s[d]), 32'(e_z));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            iv_s[d] = 1'($urandom);
            a_s[d]  = 16'($urandom);
            b_s[d]  = 16'($urandom);
            check("hold_So", 32'(so_s[d]), 32'(e_s));
            check("hold_flags", {29'd0, co_s[d], ovf_s[d], zero_s[d]}, {29'd0, e_co, e_ov, e_z});
            check("hold_handshake", {30'd0, ov_s[d], ir_s[d]}, 32'd2);
        end
        iv_s[d] = 1'b0;
        or_s[d] = 1'b1;
        @(posedge clk); #1;
        or_s[d] = 1'b0;
        check("consumed_out_valid", 32'(ov_s[d]), 32'd0);
        check("consumed_in_ready", 32'(ir_s[d]), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cur_dut      = 0;
        for (int d = 0; d < 3; d++) begin
            a_s[d] = '0; b_s[d] = '0; ci_s[d] = 1'b0; sub_s[d] = 1'b0;
            iv_s[d] = 1'b0; or_s[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            cur_dut = d;
            check("rst_So", 32'(so_s[d]), 32'd0);
            check("rst_flags", {29'd0, co_s[d], ovf_s[d], zero_s[d]}, 32'd0);
            check("rst_handshake", {30'd0, ov_s[d], ir_s[d]}, 32'd1);
        end
        rst = 1'b0;

        for (int d = 0; d < 3; d++) begin
            run_op(d, 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0);
            run_op(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
            run_op(d, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
            run_op(d, 16'h8000, 16'h0001, 1'b0, 1'b1, 0);
        end
        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, 0);
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        run_op(0, 16'hABCD, 16'h1357, 1'b1, 1'b0, 3);

        // Reset while the chunk index is 2 discards the partial result.
        cur_dut = 0;
        a_s[0] = 16'h1234; b_s[0] = 16'h0FFF; ci_s[0] = 1'b0; sub_s[0] = 1'b0;
        iv_s[0] = 1'b1;
        @(posedge clk); #1;
        iv_s[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_So", 32'(so_s[0]), 32'd0);
        check("abort_flags", {29'd0, co_s[0], ovf_s[0], zero_s[0]}, 32'd0);
        check("abort_handshake", {30'd0, ov_s[0], ir_s[0]}, 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        check("abort_no_result", 32'(ov_s[0]), 32'd0);
        run_op(0, 16'h4321, 16'h1111, 1'b1, 1'b1, 1);

        // Reset together with in_valid: nothing may be accepted.
        cur_dut = 0;
        iv_s[0] = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        iv_s[0] = 1'b0;
        check("rst_vs_valid_ready", 32'(ir_s[0]), 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        check("rst_vs_valid_no_result", 32'(ov_s[0]), 32'd0);

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                run_op(d, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom),
                       int'($urandom_range(0, 3)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
